wb_spi_array: RTL
=================

# wb_spi_array

Wishbone-slave SPI master array with `NUM_CH` channels sharing one shift engine. A single TXDATA write broadcasts one `DATA_W`-bit frame to every enabled channel in lockstep and captures each channel's MISO into its own RX register. After each frame it flags any RX disagreement between enabled channels, for mirrored-device (RAID-1 style) checking. It sits behind the Caravel user-project Wishbone bus inside the project wrapper, which tristates its outputs; pads map per channel to clk/cs/mosi/miso.

## Interface
- `NUM_CH`, default 4: channel count, range 1..8.
- `DATA_W`, default 8: frame width in bits, range 8..32.
- `DIV_W`, default 8: width of the clock-divider field.
- `wb_clk_i` in 1: the single clock; all logic on its rising edge.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i` in 1: Wishbone strobe, cycle and write enable.
- `wb_sel_i` in 4: byte selects; only full-word writes (4'hF) modify registers, partial writes are acked and ignored.
- `wb_adr_i` in 32: byte address; bits [7:2] decoded, upper bits ignored.
- `wb_dat_i` in 32: write data.
- `wb_ack_o` out 1: acknowledge.
- `wb_dat_o` out 32: read data.
- `spi_clk` out NUM_CH: SCLK per channel.
- `spi_cs` out NUM_CH: chip select per channel, active-low.
- `spi_mosi` out NUM_CH: MOSI per channel.
- `spi_miso` in NUM_CH: MISO per channel.
- `irq_o` out 1: level interrupt, equal to STATUS.done & CTRL.ie.

## Operation
- Register map (word offsets):
  - 0x00 CTRL, R/W:
    - [0] cpol, [1] cpha, [2] ie.
    - [8+DIV_W-1:8] div.
    - [24+NUM_CH-1:24] en mask.
    - Reset value 0.
  - 0x04 STATUS:
    - [0] busy (RO), [1] done, [2] mismatch, [3] overrun.
    - Bits [3:1] are write-1-to-clear.
  - 0x08 TXDATA, W: the low DATA_W bits start a frame. Reads return the last written value.
  - 0x10+4*i RXDATA[i], RO, for i < NUM_CH: the frame captured on channel i, zero-extended.
  - Unmapped addresses read 0; writes to them are ignored.
- Engine FSM: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- Half-period H = div+1 clocks.
- IDLE -> SETUP on an accepted TXDATA write:
  - cpol, cpha, div and en are latched into shadow registers.
  - done, mismatch and overrun are cleared.
  - busy is set and cs drops low on enabled channels.
- SETUP: lasts H cycles; SCLK = cpol.
  - cpha=0: MOSI already drives the MSB.
- SHIFT: 2*DATA_W half-periods, SCLK toggling every H cycles; MSB first.
  - cpha=0: sample MISO on the leading edge, shift MOSI on the trailing edge.
  - cpha=1: shift MOSI on the leading edge (the first leading edge presents the MSB), sample on the trailing edge.
  - "Sample" means the MISO value registered at the clock edge on which SCLK toggles.
- HOLD: lasts H cycles, SCLK = cpol, cs stays low. At exit:
  - cs goes high.
  - RX shift registers are copied to RXDATA.
  - mismatch is set if any two enabled channels' frames differ.
  - busy is cleared and done is set.
- Disabled channels (per the shadow mask), at all times:
  - clk = cpol (live CTRL value when idle, shadow value when busy).
  - cs = 1, mosi = 0.
  - RXDATA is unchanged.
- A mask of 0 still runs the full frame timing, sets done, and leaves mismatch = 0.
- TXDATA write while busy: acked and the data is dropped; overrun is set and the frame in flight is unaffected.
- CTRL writes while busy update the register only; they take effect at the next frame start.
- Reset values: every register is 0. Pins:
  - spi_cs = all 1.
  - spi_clk = all 0.
  - spi_mosi = all 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
- Reset mid-frame: at the next edge the FSM goes to IDLE, cs is high, clk is 0, and RXDATA keeps its reset value 0.

## Timing
- Wishbone access:
  - Accepted on the edge where stb & cyc & !ack.
  - ack is high for exactly one cycle after that edge; wb_dat_o is valid in that same cycle.
  - Minimum spacing is 2 cycles per access; there are no wait states and no error response.
- Frame timing:
  - busy and cs-low appear in the same cycle as the TXDATA-write ack.
  - Frame length is (2*DATA_W+2)*H cycles.
  - busy falls and done/irq rise in the same cycle.
- With div=0 (H=1) and DATA_W=8, busy is high for 18 cycles; SCLK runs at wb_clk_i/2.
- W1C write to done in the same cycle that the engine sets done: set wins.

## Test plan
- Reset: hold wb_rst_i for 2 cycles -> every register reads 0; spi_cs=4'hF; spi_clk=0; wb_ack_o=0.
- Mode 0 loopback: CTRL=0x0F00_0000 (div=0), miso[i] tied to mosi[i], TXDATA=0xA5 ->
  - busy for 18 cycles;
  - 8 rising SCLK edges on all channels;
  - RXDATA[0..3]=0xA5; done=1; mismatch=0.
- Mode 3 mismatch: cpol=cpha=1, div=3, mask=4'b0011; channel 0 MISO returns 0x3C, channel 1 returns 0x3D; TXDATA=0x81 ->
  - frame of 72 cycles;
  - SCLK idles high;
  - RXDATA0=0x3C, RXDATA1=0x3D; mismatch=1;
  - channels 2-3 keep cs=1 and their RXDATA unchanged.
- Overrun: TXDATA=0x11, then TXDATA=0x22 while busy ->
  - second write acked; overrun=1;
  - MOSI shifts 0x11 only.
  - Writing 0x0E to STATUS clears done, mismatch and overrun.
- Interrupt: ie=1, complete a frame -> irq_o=1 until a W1C write to done; irq_o=0 the cycle after that write's ack.
- Reset mid-frame: assert wb_rst_i at the 5th SCLK edge -> next cycle cs=all 1, busy=0, RXDATA=0; a new frame then runs normally.

Source files
------------

// File: rtl/wb_spi_array.sv
// wb_spi_array
//   Wishbone-slave SPI master array. NUM_CH channels share one shift engine,
//   so a single TXDATA write sends the same frame to every enabled channel in
//   lockstep. Each channel's MISO is captured into its own RX register. After
//   each frame, any disagreement between enabled channels is flagged, which
//   supports checking of mirrored devices.
//
// Ports
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wb_stb_i/cyc_i/we_i/sel_i    Wishbone control (only sel=4'hF writes)
//   wb_adr_i, wb_dat_i           byte address (bits [7:2] decoded), write data
//   wb_ack_o, wb_dat_o           single-cycle ack, registered read data
//   spi_clk/cs/mosi [NUM_CH]     per-channel SPI outputs (cs active-low)
//   spi_miso [NUM_CH]            per-channel SPI input
//   irq_o                        level interrupt = done & ie
module wb_spi_array #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o,
  output logic [NUM_CH-1:0] spi_clk,
  output logic [NUM_CH-1:0] spi_cs,
  output logic [NUM_CH-1:0] spi_mosi,
  input  logic [NUM_CH-1:0] spi_miso,
  output logic              irq_o
);

  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

  state_t state_reg, state_next;

  // Software-visible registers
  logic              ctrl_cpol_reg, ctrl_cpha_reg, ctrl_ie_reg;
  logic [DIV_W-1:0]  ctrl_div_reg;
  logic [NUM_CH-1:0] ctrl_en_reg;
  logic [31:0]       txdata_reg;
  logic              done_reg, mismatch_reg, overrun_reg;

  // Per-frame shadow copies so CTRL writes mid-frame cannot disturb it
  logic              sh_cpol_reg, sh_cpha_reg;
  logic [DIV_W-1:0]  sh_div_reg;
  logic [NUM_CH-1:0] sh_en_reg;

  // Shift engine
  logic [DIV_W-1:0]  cnt_reg;
  logic [HW-1:0]     half_reg;
  logic              sclk_reg, mosi_reg;
  logic [DATA_W-1:0] tx_sr_reg;
  logic [DATA_W-1:0] rx_sr_reg  [NUM_CH];
  logic [DATA_W-1:0] rxdata_reg [NUM_CH];

  logic              ack_reg;
  logic [31:0]       dat_reg;

  // Bus decode
  logic       wb_acc, wr_full, ctrl_wr, stat_wr, tx_wr;
  logic [5:0] word;
  logic       busy, start, tick, lead_ev, trail_ev, sample_ev, shift_ev, finish;
  logic       frame_mm;
  logic [31:0] rd_data;

  assign wb_acc  = wb_stb_i & wb_cyc_i & ~ack_reg;
  assign wr_full = wb_acc & wb_we_i & (wb_sel_i == 4'hF);
  assign word    = wb_adr_i[7:2];
  assign ctrl_wr = wr_full & (word == 6'd0);
  assign stat_wr = wr_full & (word == 6'd1);
  assign tx_wr   = wr_full & (word == 6'd2);

  assign busy  = (state_reg != ST_IDLE);
  assign start = tx_wr & ~busy;
  assign tick  = (cnt_reg == sh_div_reg);

  // SCLK toggles when leaving SETUP and at every half-period boundary inside
  // SHIFT except the last one, giving 2*DATA_W toggles ending back at cpol.
  // Leading edges fall on odd half indices (plus the SETUP exit).
  assign lead_ev  = tick & ((state_reg == ST_SETUP) |
                    ((state_reg == ST_SHIFT) & half_reg[0] & (half_reg != LAST_HALF)));
  assign trail_ev = tick & (state_reg == ST_SHIFT) & ~half_reg[0];
  assign sample_ev = sh_cpha_reg ? trail_ev : lead_ev;
  assign shift_ev  = sh_cpha_reg ? lead_ev  : trail_ev;
  assign finish    = tick & (state_reg == ST_HOLD);

  // Any pair of enabled channels with differing frames is a mismatch
  always_comb begin
    frame_mm = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (sh_en_reg[i] && sh_en_reg[j] && (rx_sr_reg[i] != rx_sr_reg[j]))
          frame_mm = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (word)
      6'd0: begin
        rd_data[0]             = ctrl_cpol_reg;
        rd_data[1]             = ctrl_cpha_reg;
        rd_data[2]             = ctrl_ie_reg;
        rd_data[8 +: DIV_W]    = ctrl_div_reg;
        rd_data[24 +: NUM_CH]  = ctrl_en_reg;
      end
      6'd1: rd_data[3:0] = {overrun_reg, mismatch_reg, done_reg, busy};
      6'd2: rd_data = txdata_reg;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (word == 6'(4 + i)) rd_data = 32'(rxdata_reg[i]);
        end
      end
    endcase
  end

  // Engine state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SETUP;
      ST_SETUP: if (tick) state_next = ST_SHIFT;
      ST_SHIFT: if (tick && (half_reg == LAST_HALF)) state_next = ST_HOLD;
      ST_HOLD:  if (tick) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Registers, bus response and shared shift engine
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg       <= 1'b0;
      dat_reg       <= '0;
      ctrl_cpol_reg <= 1'b0;
      ctrl_cpha_reg <= 1'b0;
      ctrl_ie_reg   <= 1'b0;
      ctrl_div_reg  <= '0;
      ctrl_en_reg   <= '0;
      txdata_reg    <= '0;
      done_reg      <= 1'b0;
      mismatch_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      sh_cpol_reg   <= 1'b0;
      sh_cpha_reg   <= 1'b0;
      sh_div_reg    <= '0;
      sh_en_reg     <= '0;
      cnt_reg       <= '0;
      half_reg      <= '0;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      tx_sr_reg     <= '0;
    end else begin
      ack_reg <= wb_acc;
      if (wb_acc) dat_reg <= rd_data;

      if (ctrl_wr) begin
        ctrl_cpol_reg <= wb_dat_i[0];
        ctrl_cpha_reg <= wb_dat_i[1];
        ctrl_ie_reg   <= wb_dat_i[2];
        ctrl_div_reg  <= wb_dat_i[8 +: DIV_W];
        ctrl_en_reg   <= wb_dat_i[24 +: NUM_CH];
      end
      if (tx_wr) txdata_reg <= wb_dat_i;
      if (stat_wr) begin
        done_reg     <= done_reg     & ~wb_dat_i[1];
        mismatch_reg <= mismatch_reg & ~wb_dat_i[2];
        overrun_reg  <= overrun_reg  & ~wb_dat_i[3];
      end
      if (tx_wr && busy) overrun_reg <= 1'b1;

      if (start) begin
        sh_cpol_reg  <= ctrl_cpol_reg;
        sh_cpha_reg  <= ctrl_cpha_reg;
        sh_div_reg   <= ctrl_div_reg;
        sh_en_reg    <= ctrl_en_reg;
        done_reg     <= 1'b0;
        mismatch_reg <= 1'b0;
        overrun_reg  <= 1'b0;
        cnt_reg      <= '0;
        half_reg     <= '0;
        sclk_reg     <= ctrl_cpol_reg;
        // cpha=0 presents the MSB during SETUP; cpha=1 presents it on the
        // first leading edge, so the whole word waits in the shifter.
        if (ctrl_cpha_reg) begin
          mosi_reg  <= 1'b0;
          tx_sr_reg <= wb_dat_i[DATA_W-1:0];
        end else begin
          mosi_reg  <= wb_dat_i[DATA_W-1];
          tx_sr_reg <= {wb_dat_i[DATA_W-2:0], 1'b0};
        end
      end else if (busy) begin
        cnt_reg <= tick ? '0 : cnt_reg + DIV_W'(1);
        if (tick && (state_reg == ST_SHIFT)) half_reg <= half_reg + HW'(1);
        if (lead_ev || trail_ev) sclk_reg <= ~sclk_reg;
        if (shift_ev) begin
          mosi_reg  <= tx_sr_reg[DATA_W-1];
          tx_sr_reg <= {tx_sr_reg[DATA_W-2:0], 1'b0};
        end
      end

      // Placed last so a same-cycle W1C of done loses to the engine's set
      if (finish) begin
        done_reg     <= 1'b1;
        mismatch_reg <= frame_mm;
        mosi_reg     <= 1'b0;
      end
    end
  end

  // Per-channel receive shifters and frame capture
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rx_sr_reg[i]  <= '0;
        rxdata_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sample_ev) rx_sr_reg[i] <= {rx_sr_reg[i][DATA_W-2:0], spi_miso[i]};
        if (finish && sh_en_reg[i]) rxdata_reg[i] <= rx_sr_reg[i];
      end
    end
  end

  // Pin drivers: disabled channels park at cpol, cs high, mosi low
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pins
    assign spi_cs[gi]   = ~(busy & sh_en_reg[gi]);
    assign spi_clk[gi]  = busy ? (sh_en_reg[gi] ? sclk_reg : sh_cpol_reg) : ctrl_cpol_reg;
    assign spi_mosi[gi] = busy & sh_en_reg[gi] & mosi_reg;
  end

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_reg;
  assign irq_o    = done_reg & ctrl_ie_reg;

  // Address bits outside [7:2] and data bits beyond the fields are don't-care
  logic unused_bits;
  assign unused_bits = &{1'b0, wb_adr_i[31:8], wb_adr_i[1:0]};

endmodule
